// File: rtl/window_3x3_gen.sv
// 3x3 RGB444 sliding-window generator: two line buffers plus a register window over a raster stream.
// Optional `WINDOW_EOF_FLAG_EN adds a win_eof output that flags the last window of each frame.
module window_3x3_gen #(
  parameter int unsigned IMG_WIDTH  = 160,
  parameter int unsigned IMG_HEIGHT = 120
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [11:0]   pix_in,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [107:0]  color_data,
  output logic          win_valid,
  output logic          busy
`ifdef WINDOW_EOF_FLAG_EN
  ,
  output logic          win_eof
`endif
);

  localparam int unsigned PIX_W = 12;
  localparam int unsigned WIN_W = 9 * PIX_W;
  localparam int unsigned XW    = $clog2(IMG_WIDTH);
  localparam int unsigned YW    = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Column layout: [0] = row y-2, [1] = row y-1, [2] = row y.
  typedef logic [2:0][PIX_W-1:0] column_t;

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  column_t            left_col_q, left_col_d;
  column_t            mid_col_q, mid_col_d;
  logic [WIN_W-1:0]   color_q, color_d;
  logic               win_valid_q, win_valid_d;
  logic               busy_q, busy_d;
`ifdef WINDOW_EOF_FLAG_EN
  logic               eof_q, eof_d;
`endif

  logic [PIX_W-1:0]   lb1_mem [IMG_WIDTH];
  logic [PIX_W-1:0]   lb2_mem [IMG_WIDTH];
  logic [XW-1:0]      col_idx_c;
  logic [PIX_W-1:0]   lb1_rd_c;
  logic [PIX_W-1:0]   lb2_rd_c;
  logic               take_c;
  logic               last_col_c;
  column_t            new_col_c;

  // A sof pixel always lands in column 0, whatever the counters held.
  assign col_idx_c  = sof ? '0 : x_q;
  assign lb1_rd_c   = lb1_mem[col_idx_c];
  assign lb2_rd_c   = lb2_mem[col_idx_c];
  assign take_c     = pix_valid && (sof || (state_q == ST_FILL) || (state_q == ST_RUN));
  assign last_col_c = (x_q == XW'(IMG_WIDTH - 1));

  always_comb begin
    new_col_c    = '0;
    new_col_c[0] = lb2_rd_c;
    new_col_c[1] = lb1_rd_c;
    new_col_c[2] = pix_in;
  end

  // Next-state logic for counters, window, FSM and registered outputs.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    left_col_d  = left_col_q;
    mid_col_d   = mid_col_q;
    color_d     = color_q;
    win_valid_d = 1'b0;
`ifdef WINDOW_EOF_FLAG_EN
    eof_d       = 1'b0;
`endif

    if (take_c) begin
      left_col_d = mid_col_q;
      mid_col_d  = new_col_c;

      if (sof) begin
        state_d = ST_FILL;
        x_d     = XW'(1);
        y_d     = '0;
      end else begin
        if (last_col_c) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end

        if ((state_q == ST_FILL) && last_col_c && (y_q == YW'(1))) begin
          state_d = ST_RUN;
        end

        // Window centred one column and one row behind the incoming pixel.
        if ((state_q == ST_RUN) && (x_q >= XW'(2))) begin
          win_valid_d = 1'b1;
          color_d     = {mid_col_q[1], left_col_q[1], new_col_c[1],
                         mid_col_q[0], mid_col_q[2],
                         left_col_q[0], new_col_c[0],
                         left_col_q[2], new_col_c[2]};
        end

        if ((state_q == ST_RUN) && last_col_c && (y_q == YW'(IMG_HEIGHT - 1))) begin
          state_d = ST_DONE;
          x_d     = '0;
          y_d     = '0;
`ifdef WINDOW_EOF_FLAG_EN
          eof_d   = 1'b1;
`endif
        end
      end
    end

    busy_d = (state_d == ST_FILL) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      left_col_q  <= '0;
      mid_col_q   <= '0;
      color_q     <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WINDOW_EOF_FLAG_EN
      eof_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      left_col_q  <= left_col_d;
      mid_col_q   <= mid_col_d;
      color_q     <= color_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
`ifdef WINDOW_EOF_FLAG_EN
      eof_q       <= eof_d;
`endif
    end
  end

  // Line buffers are read-before-write: y-1 shifts down into y-2 at the same column.
  always_ff @(posedge clk) begin
    if (take_c) begin
      lb1_mem[col_idx_c] <= pix_in;
      lb2_mem[col_idx_c] <= lb1_rd_c;
    end
  end

  assign color_data = color_q;
  assign win_valid  = win_valid_q;
  assign busy       = busy_q;
`ifdef WINDOW_EOF_FLAG_EN
  assign win_eof    = eof_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 frame with pixel value {0, y, x}.
module tb_window_3x3_gen;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [11:0]  pix_in;
  logic         pix_valid;
  logic         sof;
  logic [107:0] color_data;
  logic         win_valid;
  logic         busy;
`ifdef WINDOW_EOF_FLAG_EN
  logic         win_eof;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  logic [107:0] win_q[$];
  logic         eof_q[$];
  int           gap_errs  = 0;
  int           eof_stray = 0;
  logic         pv_prev   = 1'b0;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .color_data (color_data),
    .win_valid  (win_valid),
    .busy       (busy)
`ifdef WINDOW_EOF_FLAG_EN
    ,
    .win_eof    (win_eof)
`endif
  );

  always #5 clk = ~clk;

  // Window collector; also flags any window not preceded by an accepted pixel.
  always @(negedge clk) begin
    if (win_valid) begin
      win_q.push_back(color_data);
      if (!pv_prev) gap_errs++;
`ifdef WINDOW_EOF_FLAG_EN
      eof_q.push_back(win_eof);
`endif
    end
`ifdef WINDOW_EOF_FLAG_EN
    if (win_eof && !win_valid) eof_stray++;
`endif
    pv_prev = pix_valid;
  end

  function automatic logic [11:0] px(input int x, input int y);
    logic [3:0] xs;
    logic [3:0] ys;
    xs = 4'(x);
    ys = 4'(y);
    return {4'h0, ys, xs};
  endfunction

  function automatic logic [107:0] exp_win(input int cx, input int cy);
    return {px(cx, cy), px(cx-1, cy), px(cx+1, cy), px(cx, cy-1), px(cx, cy+1),
            px(cx-1, cy-1), px(cx+1, cy-1), px(cx-1, cy+1), px(cx+1, cy+1)};
  endfunction

  task automatic drive(input logic v, input int x, input int y, input logic s);
    pix_valid = v;
    pix_in    = px(x, y);
    sof       = s;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gaps);
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        drive(1'b1, x, y, (x == 0) && (y == 0));
        if (gaps) drive(1'b0, 15, 15, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    #1 reset_n = 1'b0;
    #2;
    n_checks++; if (win_valid !== 1'b0) begin n_errs++; $display("FAIL reset_win_valid got %b exp 0", win_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (color_data !== 108'd0) begin n_errs++; $display("FAIL reset_color got %h exp 0", color_data); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_no_sof();
    int base = win_q.size();
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++) drive(1'b1, x, y, 1'b0);
    idle(3);
    n_checks++; if (win_q.size() != base) begin n_errs++; $display("FAIL nosof_windows got %0d exp 0", win_q.size() - base); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL nosof_busy got %b exp 0", busy); end
  endtask

  task automatic test_full_frame();
    int base = win_q.size();
    int ebase = eof_q.size();
    int lo[7] = '{96, 60, 48, 84, 72, 36, 0};
    logic [11:0] ex[7] = '{12'h011, 12'h001, 12'h021, 12'h010, 12'h012, 12'h000, 12'h022};
    logic [107:0] w0;
    drive(1'b1, 0, 0, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL full_busy_fill got %b exp 1", busy); end
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        if (!(x == 0 && y == 0)) drive(1'b1, x, y, 1'b0);
    idle(3);
    n_checks++; if (win_q.size() - base != 4) begin n_errs++; $display("FAIL full_count got %0d exp 4", win_q.size() - base); end
    for (int k = 0; k < 4; k++) begin
      logic [107:0] got = (base + k < win_q.size()) ? win_q[base+k] : 'x;
      n_checks++;
      if (got !== exp_win(1 + k % 2, 1 + k / 2)) begin
        n_errs++; $display("FAIL full_win%0d got %h exp %h", k, got, exp_win(1 + k % 2, 1 + k / 2));
      end
    end
    w0 = (base < win_q.size()) ? win_q[base] : '0;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (w0[lo[i] +: 12] !== ex[i]) begin
        n_errs++; $display("FAIL full_field@%0d got %h exp %h", lo[i], w0[lo[i] +: 12], ex[i]);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL full_busy_done got %b exp 0", busy); end
`ifdef WINDOW_EOF_FLAG_EN
    for (int k = 0; k < 4; k++) begin
      logic got_e = (ebase + k < eof_q.size()) ? eof_q[ebase+k] : 1'bx;
      n_checks++;
      if (got_e !== (k == 3)) begin n_errs++; $display("FAIL eof_win%0d got %b exp %b", k, got_e, k == 3); end
    end
    n_checks++; if (eof_stray != 0) begin n_errs++; $display("FAIL eof_stray got %0d exp 0", eof_stray); end
`else
    n_checks++; if (eof_q.size() != ebase) begin n_errs++; $display("FAIL eof_absent got %0d exp 0", eof_q.size() - ebase); end
`endif
    for (int x = 0; x < 8; x++) drive(1'b1, x % 4, 3, 1'b0);
    idle(3);
    n_checks++; if (win_q.size() - base != 4) begin n_errs++; $display("FAIL done_extra got %0d exp 4", win_q.size() - base); end
  endtask

  task automatic test_gaps();
    int base = win_q.size();
    int g0 = gap_errs;
    send_frame(1'b1);
    idle(3);
    n_checks++; if (win_q.size() - base != 4) begin n_errs++; $display("FAIL gaps_count got %0d exp 4", win_q.size() - base); end
    for (int k = 0; k < 4; k++) begin
      logic [107:0] got = (base + k < win_q.size()) ? win_q[base+k] : 'x;
      n_checks++;
      if (got !== exp_win(1 + k % 2, 1 + k / 2)) begin
        n_errs++; $display("FAIL gaps_win%0d got %h exp %h", k, got, exp_win(1 + k % 2, 1 + k / 2));
      end
    end
    n_checks++; if (gap_errs != g0) begin n_errs++; $display("FAIL gaps_valid_in_gap got %0d exp 0", gap_errs - g0); end
  endtask

  task automatic test_abort();
    int base = win_q.size();
    drive(1'b1, 0, 0, 1'b1);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < int'(W); x++)
        if (!(x == 0 && y == 0) && !(y == 2 && x >= 1)) drive(1'b1, x, y, 1'b0);
    send_frame(1'b0);
    idle(3);
    n_checks++; if (win_q.size() - base != 4) begin n_errs++; $display("FAIL abort_count got %0d exp 4", win_q.size() - base); end
    for (int k = 0; k < 4; k++) begin
      logic [107:0] got = (base + k < win_q.size()) ? win_q[base+k] : 'x;
      n_checks++;
      if (got !== exp_win(1 + k % 2, 1 + k / 2)) begin
        n_errs++; $display("FAIL abort_win%0d got %h exp %h", k, got, exp_win(1 + k % 2, 1 + k / 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    drive(1'b1, 0, 0, 1'b1);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < int'(W); x++)
        if (!(x == 0 && y == 0) && !(y == 2 && x == 3)) drive(1'b1, x, y, 1'b0);
    n_checks++; if (win_valid !== 1'b1) begin n_errs++; $display("FAIL rstmid_pre_valid got %b exp 1", win_valid); end
    n_checks++; if (color_data !== exp_win(1, 1)) begin n_errs++; $display("FAIL rstmid_pre_color got %h exp %h", color_data, exp_win(1, 1)); end
    pix_valid = 1'b1; pix_in = px(3, 2);
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (win_valid !== 1'b0) begin n_errs++; $display("FAIL rstmid_valid got %b exp 0", win_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_checks++; if (color_data !== 108'd0) begin n_errs++; $display("FAIL rstmid_color got %h exp 0", color_data); end
    @(posedge clk);
    #1 pix_valid = 1'b0; reset_n = 1'b1;
    base = win_q.size();
    for (int x = 0; x < int'(W); x++) drive(1'b1, x, 3, 1'b0);
    idle(3);
    n_checks++; if (win_q.size() != base) begin n_errs++; $display("FAIL rstmid_after got %0d exp 0", win_q.size() - base); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rstmid_after_busy got %b exp 0", busy); end
    send_frame(1'b0);
    idle(3);
    n_checks++; if (win_q.size() - base != 4) begin n_errs++; $display("FAIL rstmid_new_count got %0d exp 4", win_q.size() - base); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_no_sof();
    test_full_frame();
    test_gaps();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
- REQ-001: Parameter IMG_WIDTH, default 160, pixels per line; legal range 3..1023.
- REQ-002: Parameter IMG_HEIGHT, default 120, lines per frame; legal range 3..1023.
- REQ-003: clk  input  1  single clock; all state on rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: pix_in  input  12  raster-order pixel, RGB444 {R[11:8],G[7:4],B[3:0]}.
- REQ-006: pix_valid  input  1  pix_in accepted on every rising edge where high; no backpressure.
- REQ-007: sof  input  1  start of frame; meaningful only with pix_valid; marks pixel (0,0).
- REQ-008: color_data  output  108  3x3 window: center[107:96], left[95:84], right[83:72], up[71:60], down[59:48], upleft[47:36], upright[35:24], downleft[23:12], downright[11:0].
- REQ-009: win_valid  output  1  color_data holds a new window this cycle (one-cycle pulse per window).
- REQ-010: busy  output  1  high in FILL or RUN.

Function
- REQ-011: Two line buffers, each IMG_WIDTH x 12 bits, hold lines y-1 and y-2; read/written at column x on each accepted pixel; a 3x3 register window shifts one column per accepted pixel.
- REQ-012: Column counter x wraps IMG_WIDTH-1 -> 0 and increments row counter y; both advance only on accepted pixels.
- REQ-013: FSM states IDLE, FILL, RUN, DONE; reset state IDLE.
- REQ-014: IDLE: pixels without sof ignored; pix_valid&sof -> FILL, pixel taken as (0,0).
- REQ-015: FILL: rows 0..1 written to line buffers, win_valid stays 0; accepting (IMG_WIDTH-1,1) -> RUN.
- REQ-016: RUN: accepting pixel (x,y) with x>=2 and y>=2 SHALL assert win_valid on the next cycle, color_data = window centered at (x-1,y-1); windows with x<2 not emitted (no border handling).
- REQ-017: Window mapping for center (cx,cy): up=(cx,cy-1), down=(cx,cy+1), left=(cx-1,cy), right=(cx+1,cy), diagonals accordingly.
- REQ-018: Accepting (IMG_WIDTH-1,IMG_HEIGHT-1) SHALL emit the last window and enter DONE; exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- REQ-019: DONE: pixels without sof ignored; pix_valid&sof -> FILL as in REQ-014.
- REQ-020: sof with pix_valid in FILL or RUN SHALL abort the frame: counters reset, pixel taken as (0,0), state FILL, no win_valid for that pixel; line buffer contents need not be cleared.
- REQ-021: Gaps in pix_valid SHALL not alter counters, window or line buffers; win_valid 0 during gaps.
- REQ-022: color_data holds its last value when win_valid is 0.

Reset
- REQ-023: reset_n low SHALL immediately set state IDLE, x=0, y=0, win_valid=0, busy=0, color_data=0, window registers 0; line buffer RAM not reset.
- REQ-024: Reset assertion mid-frame discards the frame; after release, output resumes only after a new sof.

Configuration
- REQ-025: Macro WINDOW_EOF_FLAG_EN defined: extra output win_eof (1 bit, reset 0) pulses with win_valid for the last window of a frame (REQ-018).
- REQ-026: WINDOW_EOF_FLAG_EN undefined: win_eof port absent; all other behaviour identical.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pix_in = {4'h0, y[3:0], x[3:0]})
- REQ-027: Full frame, pix_valid continuous from sof -> exactly 4 win_valid pulses; first after pixel (2,2): center 0x011, up 0x001, down 0x021, left 0x010, right 0x012, upleft 0x000, downright 0x022.
- REQ-028: Same frame with pix_valid low every other cycle -> identical 4 windows in order, win_valid never during gaps.
- REQ-029: Pixels without sof after reset -> win_valid 0, busy 0; then sof frame -> normal 4 windows.
- REQ-030: sof reasserted at pixel (1,2) of a frame -> no further windows from aborted frame; new frame yields 4 correct windows.
- REQ-031: reset_n pulsed low at pixel (3,2) -> outputs 0 immediately, no windows until next sof.
- REQ-032: With WINDOW_EOF_FLAG_EN -> win_eof high only with 4th window (center 0x022); after DONE, extra pixels produce nothing.
